alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : alu_arbiter
// Brief   : Round-robin arbiter sharing one multi-cycle ALU between two
//           requesters, with a WAIT-state timeout that aborts and clears the ALU.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] result,
   output logic       error,
   output logic       timeout,
   output logic       busy,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_op,
   output logic       alu_start,
   output logic       alu_clear,
   input  logic [7:0] alu_result,
   input  logic       alu_done,
   input  logic       alu_error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [7:0] C_LIMIT = 8'(TIMEOUT - 1);

   logic [1:0] state_q,   state_d;
   logic       grant_q,   grant_d;
   logic       last_q,    last_d;
   logic [3:0] a_q,       a_d;
   logic [3:0] b_q,       b_d;
   logic [1:0] op_q,      op_d;
   logic [7:0] cnt_q,     cnt_d;
   logic [7:0] res_q,     res_d;
   logic       err_q,     err_d;
   logic       tmo_q,     tmo_d;
   logic       clear_q,   clear_d;
   logic       win;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;   // requester 1 "granted last" so requester 0 wins first
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         op_q    <= 2'd0;
         cnt_q   <= 8'd0;
         res_q   <= 8'd0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         clear_q <= clear_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      clear_d = 1'b0;
      win     = (req0 && req1) ? ~last_q : req1;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               grant_d = win;
               a_d     = win ? a1  : a0;
               b_d     = win ? b1  : b0;
               op_d    = win ? op1 : op0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A done arriving on the last allowed cycle still counts as success
            if (alu_done) begin
               res_d   = alu_result;
               err_d   = alu_error;
               tmo_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == C_LIMIT) begin
               res_d   = 8'h00;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               clear_d = 1'b1;
               state_d = S_RESP;
            end
         end
         default: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      alu_start = (state_q == S_ISSUE);
      ack0      = (state_q == S_RESP) && !grant_q;
      ack1      = (state_q == S_RESP) &&  grant_q;
      result    = (state_q == S_RESP) ? res_q : 8'h00;
      error     = (state_q == S_RESP) && err_q;
      timeout   = (state_q == S_RESP) && tmo_q;
      alu_clear = clear_q;
      alu_a     = a_q;
      alu_b     = b_q;
      alu_op    = op_q;
   end

endmodule
`default_nettype wire
